// File: rtl/sint_dispatch.sv
// sint_dispatch: ray-intersection result dispatcher.
// Accepted rays travel down a fixed LAT-stage delay line alongside the
// intersection pipeline. At retire, hits go to both the traversal-arbiter
// (tarb) queue and the shadow-sample (ss) queue, and misses go to the shader
// (sh) queue. Upstream is throttled with a credit scheme: a ray is accepted
// only when every queue is guaranteed room for every ray already in flight.
// Optional build macro SINT_DISPATCH_STATS_EN adds saturating hit/miss/stall
// counters.
module sint_dispatch #(
  parameter int RAYID_W = 9,
  parameter int DEPTH   = 16,
  parameter int LAT     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [RAYID_W-1:0] in_rayID,
  input  logic               in_is_shadow,
  output logic               in_stall,
  output logic               in_accept,
  input  logic [31:0]        pl_tmin,
  input  logic [31:0]        pl_tmax,
  input  logic               pl_miss,
  output logic               tarb_valid,
  output logic [RAYID_W-1:0] tarb_rayID,
  output logic               tarb_is_shadow,
  output logic [31:0]        tarb_tmin,
  output logic [31:0]        tarb_tmax,
  input  logic               tarb_stall,
  output logic               ss_valid,
  output logic [RAYID_W-1:0] ss_rayID,
  output logic [31:0]        ss_tmax,
  input  logic               ss_stall,
  output logic               sh_valid,
  output logic [RAYID_W-1:0] sh_rayID,
  input  logic               sh_stall
`ifdef SINT_DISPATCH_STATS_EN
  ,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses,
  output logic [31:0]        stat_stall_cycles
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int SW  = CW + 2;
  localparam int TW  = RAYID_W + 65;
  localparam int SSW = RAYID_W + 32;

  // Negative tmin (including -0.0 and negative NaN) is clamped to +0.0.
  function automatic logic [31:0] clamp_tmin(input logic [31:0] t);
    return t[31] ? 32'h0 : t;
  endfunction

  // Occupancy update shared by the in-flight counter and the queues.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                             input logic push,
                                             input logic pop);
    logic [CW-1:0] r;
    r = c;
    if (push && !pop) r = c + CW'(1);
    else if (!push && pop) r = c - CW'(1);
    return r;
  endfunction

  logic [LAT-1:0]              dl_vld;
  logic [LAT-1:0][RAYID_W-1:0] dl_id;
  logic [LAT-1:0]              dl_sh;
  logic                        retire;
  logic [RAYID_W-1:0]          ret_id;
  logic                        ret_sh;
  logic [CW-1:0]               inflight, inflight_nxt;

  logic [TW-1:0]  tarb_mem [DEPTH];
  logic [AW-1:0]  tarb_wr, tarb_rd;
  logic [CW-1:0]  tarb_cnt, tarb_cnt_nxt;
  logic           tarb_push, tarb_pop;
  logic [TW-1:0]  tarb_head;

  logic [SSW-1:0] ss_mem [DEPTH];
  logic [AW-1:0]  ss_wr, ss_rd;
  logic [CW-1:0]  ss_cnt, ss_cnt_nxt;
  logic           ss_push, ss_pop;
  logic [SSW-1:0] ss_head;

  logic [RAYID_W-1:0] sh_mem [DEPTH];
  logic [AW-1:0]      sh_wr, sh_rd;
  logic [CW-1:0]      sh_cnt, sh_cnt_nxt;
  logic               sh_push, sh_pop;

  logic [CW-1:0] max_cnt_nxt;
  logic          stall_nxt;

  // Accept is suppressed while reset is held so nothing enters the pipe.
  assign in_accept = in_valid & ~in_stall & rst;

  // Delay-line valids: the only control state of the line; it never stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_vld <= '0;
    end else begin
      dl_vld[0] <= in_accept;
      for (int i = 1; i < LAT; i++) dl_vld[i] <= dl_vld[i-1];
    end
  end

  // Delay-line payload: qualified by dl_vld, so left unreset.
  always_ff @(posedge clk) begin
    dl_id[0] <= in_rayID;
    dl_sh[0] <= in_is_shadow;
    for (int i = 1; i < LAT; i++) begin
      dl_id[i] <= dl_id[i-1];
      dl_sh[i] <= dl_sh[i-1];
    end
  end

  assign retire = dl_vld[LAT-1];
  assign ret_id = dl_id[LAT-1];
  assign ret_sh = dl_sh[LAT-1];

  assign tarb_push = retire & ~pl_miss;
  assign ss_push   = retire & ~pl_miss;
  assign sh_push   = retire & pl_miss;

  assign tarb_valid = (tarb_cnt != '0);
  assign ss_valid   = (ss_cnt != '0);
  assign sh_valid   = (sh_cnt != '0);
  assign tarb_pop   = tarb_valid & ~tarb_stall;
  assign ss_pop     = ss_valid & ~ss_stall;
  assign sh_pop     = sh_valid & ~sh_stall;

  assign inflight_nxt = cnt_next(inflight, in_accept, retire);
  assign tarb_cnt_nxt = cnt_next(tarb_cnt, tarb_push, tarb_pop);
  assign ss_cnt_nxt   = cnt_next(ss_cnt, ss_push, ss_pop);
  assign sh_cnt_nxt   = cnt_next(sh_cnt, sh_push, sh_pop);

  // Show-ahead heads; outputs read as zero whenever a queue is empty.
  assign tarb_head = tarb_valid ? tarb_mem[tarb_rd] : '0;
  assign ss_head   = ss_valid ? ss_mem[ss_rd] : '0;
  assign {tarb_is_shadow, tarb_tmin, tarb_tmax, tarb_rayID} = tarb_head;
  assign {ss_tmax, ss_rayID} = ss_head;
  assign sh_rayID = sh_valid ? sh_mem[sh_rd] : '0;

  // Worst-case credit: all in-flight rays could land in the fullest queue.
  always_comb begin
    max_cnt_nxt = tarb_cnt_nxt;
    if (ss_cnt_nxt > max_cnt_nxt) max_cnt_nxt = ss_cnt_nxt;
    if (sh_cnt_nxt > max_cnt_nxt) max_cnt_nxt = sh_cnt_nxt;
    stall_nxt = (SW'(inflight_nxt) + SW'(max_cnt_nxt) + SW'(1)) > SW'(DEPTH);
  end

  // In-flight counter and registered upstream stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
      in_stall <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      in_stall <= stall_nxt;
    end
  end

  // tarb queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tarb_wr  <= '0;
      tarb_rd  <= '0;
      tarb_cnt <= '0;
    end else begin
      if (tarb_push) tarb_wr <= tarb_wr + AW'(1);
      if (tarb_pop)  tarb_rd <= tarb_rd + AW'(1);
      tarb_cnt <= tarb_cnt_nxt;
    end
  end

  // ss queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_wr  <= '0;
      ss_rd  <= '0;
      ss_cnt <= '0;
    end else begin
      if (ss_push) ss_wr <= ss_wr + AW'(1);
      if (ss_pop)  ss_rd <= ss_rd + AW'(1);
      ss_cnt <= ss_cnt_nxt;
    end
  end

  // sh queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_wr  <= '0;
      sh_rd  <= '0;
      sh_cnt <= '0;
    end else begin
      if (sh_push) sh_wr <= sh_wr + AW'(1);
      if (sh_pop)  sh_rd <= sh_rd + AW'(1);
      sh_cnt <= sh_cnt_nxt;
    end
  end

  // Queue storage writes at retire; contents are qualified by the counts.
  always_ff @(posedge clk) begin
    if (tarb_push) tarb_mem[tarb_wr] <= {ret_sh, clamp_tmin(pl_tmin), pl_tmax, ret_id};
    if (ss_push)   ss_mem[ss_wr]     <= {pl_tmax, ret_id};
    if (sh_push)   sh_mem[sh_wr]     <= ret_id;
  end

`ifdef SINT_DISPATCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hits         <= '0;
      stat_misses       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      stat_hits         <= sat_inc(stat_hits, tarb_push);
      stat_misses       <= sat_inc(stat_misses, sh_push);
      stat_stall_cycles <= sat_inc(stat_stall_cycles, in_valid & in_stall);
    end
  end
`endif

`ifndef SYNTHESIS
  tarb_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(tarb_push && !tarb_pop && (tarb_cnt == CW'(DEPTH))));
  ss_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(ss_push && !ss_pop && (ss_cnt == CW'(DEPTH))));
  sh_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(sh_push && !sh_pop && (sh_cnt == CW'(DEPTH))));
`endif

endmodule

// File: tb/tb_sint_dispatch.sv
// Testbench for sint_dispatch: directed vector table, hand-written sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_sint_dispatch;
  localparam int RID_W = 9;
  localparam int DEPTH = 16;
  localparam int LAT   = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid;
  logic [RID_W-1:0] in_rayID;
  logic             in_is_shadow;
  logic             in_stall, in_accept;
  logic [31:0]      pl_tmin, pl_tmax;
  logic             pl_miss;
  logic             tarb_valid, tarb_is_shadow, tarb_stall;
  logic [RID_W-1:0] tarb_rayID;
  logic [31:0]      tarb_tmin, tarb_tmax;
  logic             ss_valid, ss_stall;
  logic [RID_W-1:0] ss_rayID;
  logic [31:0]      ss_tmax;
  logic             sh_valid, sh_stall;
  logic [RID_W-1:0] sh_rayID;
`ifdef SINT_DISPATCH_STATS_EN
  logic [31:0]      stat_hits, stat_misses, stat_stall_cycles;
`endif

  sint_dispatch #(.RAYID_W(RID_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_rayID(in_rayID), .in_is_shadow(in_is_shadow),
    .in_stall(in_stall), .in_accept(in_accept),
    .pl_tmin(pl_tmin), .pl_tmax(pl_tmax), .pl_miss(pl_miss),
    .tarb_valid(tarb_valid), .tarb_rayID(tarb_rayID), .tarb_is_shadow(tarb_is_shadow),
    .tarb_tmin(tarb_tmin), .tarb_tmax(tarb_tmax), .tarb_stall(tarb_stall),
    .ss_valid(ss_valid), .ss_rayID(ss_rayID), .ss_tmax(ss_tmax), .ss_stall(ss_stall),
    .sh_valid(sh_valid), .sh_rayID(sh_rayID), .sh_stall(sh_stall)
`ifdef SINT_DISPATCH_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  // Pipeline response for the ray currently being offered.
  logic        drv_miss;
  logic [31:0] drv_tmin, drv_tmax;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cnt = 0;
  int m_hits, m_misses, m_stalls;

  typedef struct {
    logic [RID_W-1:0] id;
    logic             sh;
    logic             miss;
    logic [31:0]      tmin;
    logic [31:0]      tmax;
    int               stamp;
  } ray_t;

  ray_t pending[$];
  ray_t tq[$];
  ray_t sq[$];
  ray_t hq[$];
  logic [RID_W-1:0] tarb_log[$];
  logic [RID_W-1:0] ss_log[$];
  logic [RID_W-1:0] sh_log[$];

  typedef struct {
    logic [RID_W-1:0] id;
    logic             sh;
    logic             miss;
    logic [31:0]      tmin;
    logic [31:0]      tmax;
    logic             exp_tv;
    logic [31:0]      exp_tmin;
    logic             exp_shv;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Present the pipeline result LAT cycles after each accept; junk otherwise.
  always @(posedge clk) begin
    #1;
    if (pending.size() != 0 && pending[0].stamp + LAT == cyc) begin
      pl_miss = pending[0].miss;
      pl_tmin = pending[0].tmin;
      pl_tmax = pending[0].tmax;
    end else begin
      pl_miss = 1'($urandom_range(0, 1));
      pl_tmin = $urandom;
      pl_tmax = $urandom;
    end
  end

  // Reference model and scoreboard, evaluated mid-cycle.
  int   mx;
  logic exp_stall;
  ray_t r;
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ctrl", 128'({in_stall, in_accept, tarb_valid, ss_valid, sh_valid}), 128'(0));
      chk("rst_data", 128'({tarb_is_shadow, tarb_rayID, tarb_tmin, tarb_tmax,
                            ss_rayID, ss_tmax, sh_rayID}), 128'(0));
      pending.delete(); tq.delete(); sq.delete(); hq.delete();
      m_hits = 0; m_misses = 0; m_stalls = 0;
    end else begin
      mx = tq.size();
      if (sq.size() > mx) mx = sq.size();
      if (hq.size() > mx) mx = hq.size();
      exp_stall = (pending.size() + mx + 1) > DEPTH;
      chk("in_stall", 128'(in_stall), 128'(exp_stall));
      chk("in_accept", 128'(in_accept), 128'(in_valid && !exp_stall));
      if (in_valid && exp_stall) m_stalls++;

      chk("tarb_valid", 128'(tarb_valid), 128'(tq.size() != 0));
      if (tq.size() != 0)
        chk("tarb_data", 128'({tarb_rayID, tarb_is_shadow, tarb_tmin, tarb_tmax}),
            128'({tq[0].id, tq[0].sh, tq[0].tmin, tq[0].tmax}));
      if (tarb_valid && !tarb_stall) begin
        tarb_log.push_back(tarb_rayID);
        if (tq.size() != 0) void'(tq.pop_front());
      end

      chk("ss_valid", 128'(ss_valid), 128'(sq.size() != 0));
      if (sq.size() != 0)
        chk("ss_data", 128'({ss_rayID, ss_tmax}), 128'({sq[0].id, sq[0].tmax}));
      if (ss_valid && !ss_stall) begin
        ss_log.push_back(ss_rayID);
        if (sq.size() != 0) void'(sq.pop_front());
      end

      chk("sh_valid", 128'(sh_valid), 128'(hq.size() != 0));
      if (hq.size() != 0)
        chk("sh_data", 128'(sh_rayID), 128'(hq[0].id));
      if (sh_valid && !sh_stall) begin
        sh_log.push_back(sh_rayID);
        if (hq.size() != 0) void'(hq.pop_front());
      end

      if (pending.size() != 0 && pending[0].stamp + LAT == cyc) begin
        r = pending.pop_front();
        if (r.miss) begin
          hq.push_back(r);
          m_misses++;
        end else begin
          if (r.tmin[31]) r.tmin = 32'h0;
          tq.push_back(r);
          sq.push_back(r);
          m_hits++;
        end
      end

      if (in_valid && !exp_stall) begin
        r.id = in_rayID; r.sh = in_is_shadow; r.miss = drv_miss;
        r.tmin = drv_tmin; r.tmax = drv_tmax; r.stamp = cyc;
        pending.push_back(r);
        acc_cnt++;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    in_valid = 1'b1; in_rayID = v.id; in_is_shadow = v.sh;
    drv_miss = v.miss; drv_tmin = v.tmin; drv_tmax = v.tmax;
    tick(1);
    in_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk("vec_early", 128'({tarb_valid, ss_valid, sh_valid}), 128'(0));
    @(negedge clk);
    chk("vec_tarb_valid", 128'(tarb_valid), 128'(v.exp_tv));
    chk("vec_tarb_data", 128'({tarb_rayID, tarb_is_shadow, tarb_tmin, tarb_tmax}),
        v.exp_tv ? 128'({v.id, v.sh, v.exp_tmin, v.tmax}) : 128'(0));
    chk("vec_ss", 128'({ss_valid, ss_rayID, ss_tmax}),
        v.exp_tv ? 128'({1'b1, v.id, v.tmax}) : 128'(0));
    chk("vec_sh", 128'({sh_valid, sh_rayID}),
        v.exp_shv ? 128'({1'b1, v.id}) : 128'(0));
    tick(1);
  endtask

  vec_t vecs[8];
  int   s0, s1, guard;

  initial begin
    vecs[0] = '{9'd5,     1'b0, 1'b0, 32'hBF80_0000, 32'h4040_0000, 1'b1, 32'h0000_0000, 1'b0};
    vecs[1] = '{9'h1AB,   1'b1, 1'b0, 32'h3F80_0000, 32'h4120_0000, 1'b1, 32'h3F80_0000, 1'b0};
    vecs[2] = '{9'h0FF,   1'b0, 1'b1, 32'h1234_5678, 32'h4000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[3] = '{9'h1FF,   1'b1, 1'b0, 32'h8000_0000, 32'h3F00_0000, 1'b1, 32'h0000_0000, 1'b0};
    vecs[4] = '{9'd0,     1'b0, 1'b0, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7F80_0000, 1'b0};
    vecs[5] = '{9'h100,   1'b1, 1'b1, 32'hC000_0000, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[6] = '{9'd3,     1'b0, 1'b0, 32'hFFC0_0000, 32'h4100_0000, 1'b1, 32'h0000_0000, 1'b0};
    vecs[7] = '{9'h055,   1'b1, 1'b0, 32'h0000_0001, 32'hDEAD_BEEF, 1'b1, 32'h0000_0001, 1'b0};

    rst = 1'b0; in_valid = 1'b0; in_rayID = '0; in_is_shadow = 1'b0;
    drv_miss = 1'b0; drv_tmin = '0; drv_tmax = '0;
    pl_miss = 1'b0; pl_tmin = '0; pl_tmax = '0;
    tarb_stall = 1'b0; ss_stall = 1'b0; sh_stall = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);

    // Single-ray vectors: clamp rule and routing.
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Rays 1..4, alternating miss/hit, back to back.
    tarb_log.delete(); ss_log.delete(); sh_log.delete();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_rayID = RID_W'(i); in_is_shadow = 1'b0;
      drv_miss = (i % 2 == 1); drv_tmin = $urandom; drv_tmax = $urandom;
      tick(1);
    end
    in_valid = 1'b0;
    tick(LAT + 8);
    chk("seq4_sh_n", 128'(sh_log.size()), 128'(2));
    chk("seq4_tarb_n", 128'(tarb_log.size()), 128'(2));
    chk("seq4_ss_n", 128'(ss_log.size()), 128'(2));
    if (sh_log.size() == 2) chk("seq4_sh_order", 128'({sh_log[0], sh_log[1]}), 128'({9'd1, 9'd3}));
    if (tarb_log.size() == 2) chk("seq4_tarb_order", 128'({tarb_log[0], tarb_log[1]}), 128'({9'd2, 9'd4}));
    if (ss_log.size() == 2) chk("seq4_ss_order", 128'({ss_log[0], ss_log[1]}), 128'({9'd2, 9'd4}));

    // tarb backpressure: exactly DEPTH accepts, then upstream stalls.
    tarb_stall = 1'b1;
    s0 = acc_cnt;
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1; in_rayID = RID_W'(i + 32); drv_miss = 1'b0;
      drv_tmin = $urandom; drv_tmax = $urandom;
      tick(1);
    end
    chk("bp_accepts", 128'(acc_cnt - s0), 128'(DEPTH));
    chk("bp_in_stall", 128'(in_stall), 128'(1));
    chk("bp_ss_drained", 128'(ss_valid), 128'(0));
    chk("bp_tarb_held", 128'(tarb_valid), 128'(1));
    tarb_stall = 1'b0;
    s1 = acc_cnt;
    for (int i = 0; i < 40; i++) begin
      in_rayID = RID_W'(i + 100); drv_tmin = $urandom; drv_tmax = $urandom;
      tick(1);
    end
    chk("bp_resumed", 128'(acc_cnt > s1), 128'(1));
    in_valid = 1'b0;
    tick(LAT + DEPTH + 10);

    // Reset with 10 rays in flight and 5 queued.
    sh_stall = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; in_rayID = RID_W'(200 + i); drv_miss = 1'b1;
      drv_tmin = $urandom; drv_tmax = $urandom;
      tick(1);
    end
    in_valid = 1'b0;
    tick(LAT + 5 - 15);
    chk("pre_rst_queued", 128'(sh_valid), 128'(1));
    rst = 1'b0;
    tick(1);
    chk("in_rst_ctrl", 128'({in_stall, tarb_valid, ss_valid, sh_valid}), 128'(0));
    rst = 1'b1; sh_stall = 1'b0;
    tarb_log.delete(); ss_log.delete(); sh_log.delete();
    tick(LAT + DEPTH + 5);
    chk("post_rst_no_out", 128'(sh_log.size() + tarb_log.size() + ss_log.size()), 128'(0));
    chk("post_rst_stall", 128'(in_stall), 128'(0));

    // Random traffic, miss-heavy, with toggling output stalls.
    s0 = acc_cnt;
    guard = 0;
    while (acc_cnt - s0 < 1000 && guard < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_rayID = RID_W'($urandom);
      in_is_shadow = 1'($urandom_range(0, 1));
      drv_miss = ($urandom_range(0, 3) != 0);
      drv_tmin = $urandom; drv_tmax = $urandom;
      sh_stall = ~sh_stall ^ ($urandom_range(0, 3) == 0);
      tarb_stall = ($urandom_range(0, 3) == 0);
      ss_stall = ($urandom_range(0, 2) == 0);
      tick(1);
      guard++;
    end
    chk("rand_accepts", 128'(acc_cnt - s0 >= 1000), 128'(1));
    in_valid = 1'b0; sh_stall = 1'b0; tarb_stall = 1'b0; ss_stall = 1'b0;
    tick(LAT + DEPTH + 10);
    chk("rand_drained", 128'(pending.size() + tq.size() + sq.size() + hq.size()), 128'(0));
    chk("rand_valids", 128'({tarb_valid, ss_valid, sh_valid}), 128'(0));

`ifdef SINT_DISPATCH_STATS_EN
    chk("stat_hits", 128'(stat_hits), 128'(m_hits));
    chk("stat_misses", 128'(stat_misses), 128'(m_misses));
    chk("stat_stall_cycles", 128'(stat_stall_cycles), 128'(m_stalls));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sint_dispatch.md
SINT_DISPATCH -- requirements
Module: sint_dispatch

Interface
REQ-001 The block SHALL take parameter RAYID_W, default 9, meaning the ray identifier width.
REQ-002 The block SHALL take parameter DEPTH, default 16 (power of two, 4..64), meaning the entries per output queue.
REQ-003 The block SHALL take parameter LAT, default 18 (>=1), meaning the cycles from in_accept to matching pl_* result.
REQ-004 The block SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have ports: in_valid in 1 ray offered; in_rayID in RAYID_W; in_is_shadow in 1; in_stall out 1 upstream backpressure; in_accept out 1 ray taken this cycle.
REQ-006 The block SHALL have ports: pl_tmin in 32 float; pl_tmax in 32 float; pl_miss in 1; all sampled LAT cycles after the matching in_accept.
REQ-007 The block SHALL have ports: tarb_valid out 1; tarb_rayID out RAYID_W; tarb_is_shadow out 1; tarb_tmin out 32; tarb_tmax out 32; tarb_stall in 1.
REQ-008 The block SHALL have ports: ss_valid out 1; ss_rayID out RAYID_W; ss_tmax out 32; ss_stall in 1.
REQ-009 The block SHALL have ports: sh_valid out 1; sh_rayID out RAYID_W; sh_stall in 1.

Function
REQ-010 in_accept SHALL equal in_valid & ~in_stall.
REQ-011 in_stall SHALL be registered and asserted iff, for any queue Q, inflight + count(Q) + 1 > DEPTH, computed from next-state values; it is independent of in_valid.
REQ-012 A delay line of LAT stages SHALL carry {valid, rayID, is_shadow} from in_accept to the retire point; the line never stalls.
REQ-013 inflight SHALL increment on in_accept, decrement on retire (delay-line output valid), hold when both happen in the same cycle.
REQ-014 On retire with pl_miss=0, the entry SHALL be written to the tarb queue and the ss queue in the same cycle.
REQ-015 On retire with pl_miss=1, rayID SHALL be written to the shader queue only.
REQ-016 Before the write, tmin SHALL be clamped: if pl_tmin[31]=1, the stored value SHALL be 32'h0; tmax SHALL be stored unchanged.
REQ-017 Each queue SHALL be a first-in-first-out buffer with show-ahead output; X_valid = ~empty; pop on X_valid & ~X_stall.
REQ-018 Each queue SHALL support a simultaneous push and pop, including when full or empty, with count unchanged.
REQ-019 Each queue's pointers SHALL wrap modulo DEPTH; count width is $clog2(DEPTH)+1.
REQ-020 The credit rule SHALL guarantee no push to a full queue; a push to a full queue is a design error flagged by a simulation assertion.
REQ-021 Queues SHALL drain independently; a stall on one output SHALL NOT block the other outputs.

Reset
REQ-022 While rst=0: all queues empty, inflight=0, delay-line valids 0, in_stall=0, in_accept=0, tarb_valid=ss_valid=sh_valid=0, and data outputs 0.
REQ-023 Reset asserted mid-operation SHALL discard all queued and in-flight rays; no retire occurs in the first LAT cycles after release.

Configuration
REQ-024 With macro SINT_DISPATCH_STATS_EN defined, the block SHALL add these outputs: stat_hits out 32, stat_misses out 32, stat_stall_cycles out 32.
REQ-025 The stat counters SHALL saturate at 32'hFFFFFFFF and reset to 0. Hits count retires with pl_miss=0, misses count retires with pl_miss=1, and stall cycles count in_valid & in_stall.
REQ-026 Without SINT_DISPATCH_STATS_EN, the block SHALL have no stat ports or counters, and behaviour is otherwise identical.

Verification
REQ-027 Reset then a single ray rayID=5, shadow=0, pl_miss=0, tmin=-1.0, tmax=3.0 SHALL give, LAT+1 cycles after accept: tarb_valid with tmin=0, tmax=32'h40400000; ss_valid with rayID=5; sh_valid=0.
REQ-028 Rays 1..4 with pl_miss=1,0,1,0 and no stalls SHALL give shader outputs 1, 3 in order and tarb/ss outputs 2, 4 in order.
REQ-029 With DEPTH=16 and tarb_stall held high while rays are offered every cycle: exactly 16 accepts occur, then in_stall=1; ss drains, tarb holds 16; releasing tarb_stall resumes accepts.
REQ-030 Simultaneous push and pop on a full shader queue while sh_stall toggles SHALL lose and duplicate no rayID across 1000 random rays checked against a scoreboard.
REQ-031 Reset asserted for 1 cycle with 10 rays in flight and 5 queued SHALL give all valids 0, no outputs for those rays after release, and in_stall=0.
REQ-032 With SINT_DISPATCH_STATS_EN, 7 hits, 3 misses and 4 stalled offer cycles SHALL read stat_hits=7, stat_misses=3, stat_stall_cycles=4.
